mem_system_dm_wt: RTL and testbench

- Parametrised direct-mapped L1 memory system: data/tag/valid arrays, a fill and write-through FSM, and an off-chip request/acknowledge interface. It is the next-generation memory wrapper.
- Sits between the core pipeline (instruction or data port) and the off-chip DRAM model.
- Adds configurable geometry, valid bits, write-through with no-write-allocate, and single-outstanding handshaked fills.

---
 rtl/mem_system_dm_wt.sv | 208 ++++++++++++++++++++
 tb/tb_mem_system_dm_wt.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_system_dm_wt.sv
// mem_system_dm_wt
// Direct-mapped L1 memory system with write-through, no-write-allocate policy
// and single-outstanding handshaked block fills from off-chip DRAM.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   enable, on_chip_wr          core request valid, 1 = write / 0 = read
//   on_chip_addr, on_chip_wdata core byte address and write data
//   data_out, hit, fsm_busy     read data, tag hit, stall to the core
//   off_chip_addr               DRAM byte address
//   off_chip_rd_req/rdata/rvalid  block fill handshake (one word per beat)
//   off_chip_wr_req/wdata/wack    write-through handshake
//
// Optional build macro MEM_SYS_STATS_EN adds saturating hit_count,
// miss_count and wr_count outputs.
module mem_system_dm_wt #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              on_chip_wr,
    input  logic [ADDR_W-1:0] on_chip_addr,
    input  logic [DATA_W-1:0] on_chip_wdata,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              fsm_busy,
    output logic [ADDR_W-1:0] off_chip_addr,
    output logic              off_chip_rd_req,
    input  logic [DATA_W-1:0] off_chip_rdata,
    input  logic              off_chip_rvalid,
    output logic              off_chip_wr_req,
    output logic [DATA_W-1:0] off_chip_wdata,
    input  logic              off_chip_wack
`ifdef MEM_SYS_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int BO = $clog2(DATA_W / 8);
    localparam int WO = $clog2(WORDS);
    localparam int IX = $clog2(SETS);
    localparam int TW = ADDR_W - IX - WO - BO;
    localparam logic [WO-1:0]     LAST     = WO'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << (BO + WO)) - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q;
    logic [WO-1:0]     cnt_q;
    logic [WO-1:0]     cnt_d;
    logic [ADDR_W-1:0] base_q;
    logic [SETS-1:0]   valid_q;
    logic              rdReq_q;
    logic              wrReq_q;
    logic [ADDR_W-1:0] offAddr_q;
    logic [DATA_W-1:0] offWdata_q;

    logic [DATA_W-1:0] dataArr_q [SETS*WORDS];
    logic [TW-1:0]     tagArr_q  [SETS];

    logic [TW-1:0]     reqTag;
    logic [IX-1:0]     reqIdx;
    logic [WO-1:0]     reqWord;
    logic [TW-1:0]     baseTag;
    logic [IX-1:0]     baseIdx;
    logic              fillLast;

    logic              memWe;
    logic [IX+WO-1:0]  memAddr;
    logic [DATA_W-1:0] memWdata;

    assign reqTag  = on_chip_addr[ADDR_W-1 -: TW];
    assign reqIdx  = on_chip_addr[BO+WO +: IX];
    assign reqWord = on_chip_addr[BO +: WO];
    assign baseTag = base_q[ADDR_W-1 -: TW];
    assign baseIdx = base_q[BO+WO +: IX];

    assign cnt_d    = cnt_q + WO'(1);
    assign fillLast = (state_q == FILL) && off_chip_rvalid && (cnt_q == LAST);

    assign hit      = valid_q[reqIdx] && (tagArr_q[reqIdx] == reqTag);
    assign data_out = (enable && hit) ? dataArr_q[{reqIdx, reqWord}] : '0;
    assign fsm_busy = ((state_q == IDLE) && enable && (!hit || on_chip_wr))
                    || (state_q != IDLE);

    assign off_chip_addr   = offAddr_q;
    assign off_chip_rd_req = rdReq_q;
    assign off_chip_wr_req = wrReq_q;
    assign off_chip_wdata  = offWdata_q;

    // Fill beats and write hits share one data-array write port; the two
    // can never coincide because they belong to different FSM states.
    always_comb begin
        memWe    = 1'b0;
        memAddr  = {reqIdx, reqWord};
        memWdata = on_chip_wdata;
        if ((state_q == IDLE) && enable && on_chip_wr && hit) begin
            memWe = 1'b1;
        end else if ((state_q == FILL) && off_chip_rvalid) begin
            memWe    = 1'b1;
            memAddr  = {baseIdx, cnt_q};
            memWdata = off_chip_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            dataArr_q[memAddr] <= memWdata;
        end
        if (fillLast) begin
            tagArr_q[baseIdx] <= baseTag;
        end
    end

    // Control FSM. The set is invalidated when a fill starts so a half-loaded
    // block can never hit under the old tag; the off-chip address register
    // always holds the address of the beat currently requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            valid_q    <= '0;
            rdReq_q    <= 1'b0;
            wrReq_q    <= 1'b0;
            offAddr_q  <= '0;
            offWdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && on_chip_wr) begin
                        state_q    <= WRITE;
                        wrReq_q    <= 1'b1;
                        offAddr_q  <= on_chip_addr;
                        offWdata_q <= on_chip_wdata;
                    end else if (enable && !hit) begin
                        state_q         <= FILL;
                        base_q          <= on_chip_addr & BLK_MASK;
                        offAddr_q       <= on_chip_addr & BLK_MASK;
                        cnt_q           <= '0;
                        rdReq_q         <= 1'b1;
                        valid_q[reqIdx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (off_chip_rvalid) begin
                        cnt_q     <= cnt_d;
                        offAddr_q <= base_q | (ADDR_W'(cnt_d) << BO);
                        if (cnt_q == LAST) begin
                            valid_q[baseIdx] <= 1'b1;
                            rdReq_q          <= 1'b0;
                            state_q          <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (off_chip_wack) begin
                        wrReq_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_SYS_STATS_EN
    logic [31:0] hitCnt_q;
    logic [31:0] missCnt_q;
    logic [31:0] wrCnt_q;

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
            wrCnt_q   <= '0;
        end else if (state_q == IDLE) begin
            if (enable && hit && !fsm_busy && (hitCnt_q != '1)) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if (enable && !on_chip_wr && !hit && (missCnt_q != '1)) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
            if (enable && on_chip_wr && (wrCnt_q != '1)) begin
                wrCnt_q <= wrCnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hitCnt_q;
    assign miss_count = missCnt_q;
    assign wr_count   = wrCnt_q;
`endif

endmodule

// File: tb/tb_mem_system_dm_wt.sv
// tb_mem_system_dm_wt
// Directed bench for mem_system_dm_wt. A DRAM model answers fill beats every
// second cycle and writes on the third; expected read data, fill beat
// addresses and write-through transfers are queued when a request is issued
// and popped by an independent monitor when the DUT presents them.
module tb_mem_system_dm_wt;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        on_chip_wr;
    logic [15:0] on_chip_addr;
    logic [15:0] on_chip_wdata;
    logic [15:0] data_out;
    logic        hit;
    logic        fsm_busy;
    logic [15:0] off_chip_addr;
    logic        off_chip_rd_req;
    logic [15:0] off_chip_rdata;
    logic        off_chip_rvalid;
    logic        off_chip_wr_req;
    logic [15:0] off_chip_wdata;
    logic        off_chip_wack;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] rdQ[$];
    logic [15:0] fillQ[$];
    logic [31:0] wrQ[$];
    logic [15:0] dramWr[logic [15:0]];
    int          dramWait = 0;

    mem_system_dm_wt dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .on_chip_wr      (on_chip_wr),
        .on_chip_addr    (on_chip_addr),
        .on_chip_wdata   (on_chip_wdata),
        .data_out        (data_out),
        .hit             (hit),
        .fsm_busy        (fsm_busy),
        .off_chip_addr   (off_chip_addr),
        .off_chip_rd_req (off_chip_rd_req),
        .off_chip_rdata  (off_chip_rdata),
        .off_chip_rvalid (off_chip_rvalid),
        .off_chip_wr_req (off_chip_wr_req),
        .off_chip_wdata  (off_chip_wdata),
        .off_chip_wack   (off_chip_wack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unwritten DRAM words hold their own byte address plus 0x1000.
    function automatic logic [15:0] dramRead(input logic [15:0] a);
        if (dramWr.exists(a)) return dramWr[a];
        return a + 16'h1000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // DRAM model, driven just after each rising edge.
    initial begin
        off_chip_rvalid = 1'b0;
        off_chip_wack   = 1'b0;
        off_chip_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            off_chip_rvalid = 1'b0;
            off_chip_wack   = 1'b0;
            if (!rst_n) begin
                dramWait = 0;
            end else if (off_chip_rd_req) begin
                if (dramWait == RD_LAT - 1) begin
                    off_chip_rvalid = 1'b1;
                    off_chip_rdata  = dramRead(off_chip_addr);
                    dramWait = 0;
                end else begin
                    dramWait++;
                end
            end else if (off_chip_wr_req) begin
                if (dramWait == WR_LAT - 1) begin
                    off_chip_wack = 1'b1;
                    dramWr[off_chip_addr] = off_chip_wdata;
                    dramWait = 0;
                end else begin
                    dramWait++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (enable && !on_chip_wr && !fsm_busy) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_read_done", 32'd1, 32'd0);
                end else begin
                    checkOutput("rd_data", 32'(data_out), 32'(rdQ.pop_front()));
                    checkOutput("rd_hit", 32'(hit), 32'd1);
                end
            end
            if (off_chip_rd_req && off_chip_rvalid) begin
                if (fillQ.size() == 0) begin
                    checkOutput("unexpected_fill_beat", 32'(off_chip_addr), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("fill_addr", 32'(off_chip_addr), 32'(fillQ.pop_front()));
                end
            end
            if (off_chip_wr_req && off_chip_wack) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'(off_chip_addr), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("wr_addr_data", {off_chip_addr, off_chip_wdata},
                                wrQ.pop_front());
                end
            end
            if (off_chip_rd_req && off_chip_wr_req) begin
                checkOutput("both_req_high", 32'd1, 32'd0);
            end
        end
    end

    task automatic pushFill(input logic [15:0] addr, input int beats);
        for (int i = 0; i < beats; i++) begin
            fillQ.push_back((addr & 16'hFFF0) + 16'(2 * i));
        end
    endtask

    // Issues one core request and holds it until the DUT completes it.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                                 input logic [15:0] data, input logic expMiss);
        bit done;
        if (wr) begin
            wrQ.push_back({addr, data});
        end else begin
            rdQ.push_back(data);
            if (expMiss) pushFill(addr, 8);
        end
        @(posedge clk);
        #1;
        enable        = 1'b1;
        on_chip_wr    = wr;
        on_chip_addr  = addr;
        on_chip_wdata = data;
        @(negedge clk);
        checkOutput("busy_first_cycle", 32'(fsm_busy), 32'(wr | expMiss));
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (wr) begin
                if (off_chip_wr_req && off_chip_wack) done = 1'b1;
            end else if (!fsm_busy) begin
                done = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        if (!done) checkOutput("request_timeout", 32'(addr), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        enable     = 1'b0;
        on_chip_wr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit done;
        rst_n         = 1'b0;
        enable        = 1'b0;
        on_chip_wr    = 1'b0;
        on_chip_addr  = 16'h0412;
        on_chip_wdata = '0;
        #12;
        checkOutput("rst_rd_req", 32'(off_chip_rd_req), 32'd0);
        checkOutput("rst_wr_req", 32'(off_chip_wr_req), 32'd0);
        checkOutput("rst_off_addr", 32'(off_chip_addr), 32'd0);
        checkOutput("rst_off_wdata", 32'(off_chip_wdata), 32'd0);
        checkOutput("rst_hit", 32'(hit), 32'd0);
        checkOutput("rst_busy", 32'(fsm_busy), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        #11 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] cold read, hits, write-through");
        applyStimulus(1'b0, 16'h0412, 16'h1412, 1'b1);
        applyStimulus(1'b0, 16'h041C, 16'h141C, 1'b0);
        applyStimulus(1'b1, 16'h0414, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 16'h0414, 16'hBEEF, 1'b0);

        $display("[TB] write miss, no allocate");
        applyStimulus(1'b1, 16'h8000, 16'h1234, 1'b0);
        applyStimulus(1'b0, 16'h8000, 16'h1234, 1'b1);

        $display("[TB] conflict eviction");
        applyStimulus(1'b0, 16'h4412, 16'h5412, 1'b1);
        applyStimulus(1'b0, 16'h0412, 16'h1412, 1'b1);

        $display("[TB] reset during fill");
        pushFill(16'h4412, 4);
        @(posedge clk);
        #1;
        enable       = 1'b1;
        on_chip_wr   = 1'b0;
        on_chip_addr = 16'h4412;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if (fillQ.size() == 0) done = 1'b1;
        end
        if (!done) checkOutput("partial_fill_timeout", 32'(fillQ.size()), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rd_req", 32'(off_chip_rd_req), 32'd0);
        checkOutput("midrst_wr_req", 32'(off_chip_wr_req), 32'd0);
        checkOutput("midrst_off_addr", 32'(off_chip_addr), 32'd0);
        checkOutput("midrst_hit", 32'(hit), 32'd0);
        repeat (2) @(posedge clk);
        pushFill(16'h4412, 8);
        rdQ.push_back(16'h5412);
        #3 rst_n = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!fsm_busy) done = 1'b1;
        end
        if (!done) checkOutput("refill_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (4) @(posedge clk);

        checkOutput("rdQ_drained", 32'(rdQ.size()), 32'd0);
        checkOutput("fillQ_drained", 32'(fillQ.size()), 32'd0);
        checkOutput("wrQ_drained", 32'(wrQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
